// File: rtl/inst_sram_axi_bridge.sv
// IF-side sram-like to AXI3 single-beat read bridge; one outstanding read, 3-cycle min latency (accept, AR, R).
// AR stalls on arready, R waits on rvalid; addrok is held low until the read retires.
module inst_sram_axi_bridge #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  input  logic        ws_cancel,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t     state, state_nxt;
  logic [1:0] size_r;
  logic       discard, discard_nxt;
  logic       accept, beat;
  logic       unused_inputs;

  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast};

  // addrok is a function of state only; IF builds req from it
  assign inst_sram_addrok = (state == IDLE) && !reset;
  assign accept           = inst_sram_req && inst_sram_addrok;
  assign arvalid          = (state == AR) && !reset;
  assign rready           = (state == R) && !reset;
  assign beat             = rvalid && rready && (rid == ARID_VAL);
  assign inst_sram_dataok = beat && !discard && !ws_cancel;
  assign inst_sram_rdata  = rdata;

  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_r};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    case (state)
      IDLE:    if (accept) state_nxt = AR;
      AR:      if (arready) state_nxt = R;
      R:       if (beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // a flush landing on the returning beat already suppresses it, so nothing is left to discard
    if (beat)
      discard_nxt = 1'b0;
    else if (ws_cancel && (accept || state != IDLE))
      discard_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      discard <= 1'b0;
      araddr  <= 32'd0;
      size_r  <= 2'd0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if (accept) begin
        araddr <= inst_sram_addr;
        size_r <= inst_sram_size;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: cycle table plus back-to-back and reset-in-AR sequences.
module tb_inst_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        addrok, dataok;
  logic [31:0] inst_rdata;
  logic        cancel = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_addr(addr),
    .inst_sram_wstrb(wstrb), .inst_sram_wdata(wdata),
    .inst_sram_addrok(addrok), .inst_sram_dataok(dataok), .inst_sram_rdata(inst_rdata),
    .ws_cancel(cancel),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic        rst, req;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        cancel, arready, rvalid;
    logic [3:0]  rid;
    logic [31:0] rdat;
    logic        e_addrok, e_arvalid;
    logic [31:0] e_araddr;
    logic [2:0]  e_arsize;
    logic        e_rready, e_dataok;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic q, logic [31:0] a, logic [1:0] s, logic c,
                              logic ar, logic rv, logic [3:0] id, logic [31:0] d,
                              logic eok, logic eav, logic [31:0] ea, logic [2:0] es,
                              logic err, logic edk);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.size = s; v.cancel = c;
    v.arready = ar; v.rvalid = rv; v.rid = id; v.rdat = d;
    v.e_addrok = eok; v.e_arvalid = eav; v.e_araddr = ea; v.e_arsize = es;
    v.e_rready = err; v.e_dataok = edk;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, dk, hs;
    logic pend;

    // reset
    add(1,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,0,0);
    add(1,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,0,0);
    // single fetch, zero-wait
    add(0,1,32'h1fc00000,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00000,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h3c1d0001,     0,0,32'd0,3'd0,1,1);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            1,0,32'd0,3'd0,0,0);
    // AR backpressure; req stays high with a different address while blocked
    add(0,1,32'h1fc00004,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    for (int i = 0; i < 3; i++)
      add(0,1,32'h0bad0000,2'd0,0,0,0,4'd0,32'd0,   0,1,32'h1fc00004,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00004,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h11111111,     0,0,32'd0,3'd0,1,1);
    // R wait states, halfword size, one wrong-rid beat in the middle
    add(0,1,32'h1fc00008,2'd1,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00008,3'd1,0,0);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd5,32'hdeadbeef,     0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h22222222,     0,0,32'd0,3'd0,1,1);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            1,0,32'd0,3'd0,0,0);
    // cancel in R before rvalid, then a fresh fetch
    add(0,1,32'h1fc00010,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00010,3'd2,0,0);
    add(0,0,32'd0,2'd0,1,0,0,4'd0,32'd0,            0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'hdeadbeef,     0,0,32'd0,3'd0,1,0);
    add(0,1,32'h1fc00380,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00380,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h33333333,     0,0,32'd0,3'd0,1,1);
    // cancel at accept
    add(0,1,32'h1fc00020,2'd2,1,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00020,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h44444444,     0,0,32'd0,3'd0,1,0);
    // cancel in IDLE without a request has no effect on the next fetch
    add(0,0,32'd0,2'd0,1,0,0,4'd0,32'd0,            1,0,32'd0,3'd0,0,0);
    add(0,1,32'h1fc00040,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00040,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h55555555,     0,0,32'd0,3'd0,1,1);
    // cancel coinciding with the R beat; following fetch must not be discarded
    add(0,1,32'h1fc00044,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00044,3'd2,0,0);
    add(0,0,32'd0,2'd0,1,0,1,4'd0,32'h66666666,     0,0,32'd0,3'd0,1,0);
    add(0,1,32'h1fc00048,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc00048,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h77777777,     0,0,32'd0,3'd0,1,1);
    // cancel while AR is stalled
    add(0,1,32'h1fc0004c,2'd2,0,0,0,4'd0,32'd0,     1,0,32'd0,3'd0,0,0);
    add(0,0,32'd0,2'd0,1,0,0,4'd0,32'd0,            0,1,32'h1fc0004c,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,1,0,4'd0,32'd0,            0,1,32'h1fc0004c,3'd2,0,0);
    add(0,0,32'd0,2'd0,0,0,1,4'd0,32'h88888888,     0,0,32'd0,3'd0,1,0);
    add(0,0,32'd0,2'd0,0,0,0,4'd0,32'd0,            1,0,32'd0,3'd0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; req = tbl[i].req; addr = tbl[i].addr; size = tbl[i].size;
      cancel = tbl[i].cancel; arready = tbl[i].arready; rvalid = tbl[i].rvalid;
      rid = tbl[i].rid; rdata = tbl[i].rdat;
      @(negedge clk);
      check($sformatf("v%0d addrok", i), 32'(addrok), 32'(tbl[i].e_addrok));
      check($sformatf("v%0d arvalid", i), 32'(arvalid), 32'(tbl[i].e_arvalid));
      check($sformatf("v%0d rready", i), 32'(rready), 32'(tbl[i].e_rready));
      check($sformatf("v%0d dataok", i), 32'(dataok), 32'(tbl[i].e_dataok));
      if (tbl[i].e_arvalid) begin
        check($sformatf("v%0d araddr", i), araddr, tbl[i].e_araddr);
        check($sformatf("v%0d arsize", i), 32'(arsize), 32'(tbl[i].e_arsize));
        check($sformatf("v%0d arlen", i), 32'(arlen), 32'd0);
      end
      if (tbl[i].e_dataok)
        check($sformatf("v%0d rdata", i), inst_rdata, tbl[i].rdat);
      @(posedge clk); #1;
    end

    // back-to-back: req held, zero-wait slave answering the cycle after each AR handshake
    acc = 0; dk = 0; hs = 0;
    req = 1'b1; addr = 32'h1fc00100; size = 2'd2; cancel = 1'b0;
    arready = 1'b1; rvalid = 1'b0; rid = 4'd0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (addrok && req) begin
        check("b2b accept cycle", 32'(c), 32'(3 * acc));
        acc++;
      end
      if (arvalid)
        check("b2b araddr", araddr, 32'h1fc00100 + 32'(4 * hs));
      if (dataok) begin
        check("b2b rdata", inst_rdata, 32'hc0de0000 + 32'(dk));
        check("b2b dataok cycle", 32'(c), 32'(3 * dk + 2));
        dk++;
      end
      pend = arvalid && arready;
      @(posedge clk); #1;
      req = (acc < 4);
      addr = 32'h1fc00100 + 32'(4 * acc);
      rvalid = pend;
      rdata = 32'hc0de0000 + 32'(hs);
      if (pend) hs++;
    end
    check("b2b accepts", 32'(acc), 32'd4);
    check("b2b dataoks", 32'(dk), 32'd4);

    // reset while the AR is stalled
    req = 1'b1; addr = 32'h1fc000c0; arready = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    check("rst-ar accept", 32'(addrok), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("rst-ar arvalid before", 32'(arvalid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst-ar addrok in reset", 32'(addrok), 32'd0);
    check("rst-ar arvalid in reset", 32'(arvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; rvalid = 1'b1; rdata = 32'hbadbad00;
    @(negedge clk);
    check("rst-ar arvalid after", 32'(arvalid), 32'd0);
    check("rst-ar addrok after", 32'(addrok), 32'd1);
    check("rst-ar dataok after", 32'(dataok), 32'd0);
    check("rst-ar rready after", 32'(rready), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_sram_axi_bridge.md
Name: inst_sram_axi_bridge

Overview:
Read-only bridge between the IF stage's instruction sram-like port and a 32-bit AXI3 read channel; it sits directly upstream of IF and supplies its addrok, dataok and rdata.
It holds one outstanding single-beat read.
On a writeback-stage cancel it discards the in-flight response, so IF never sees a stale instruction after a flush.

Parameters:
ARID_VAL, 4'd0, constant driven on arid; rid is compared against it.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
inst_sram_req  in  1  request from IF
inst_sram_wr  in  1  write flag; IF ties it to 0; ignored, every request is a read
inst_sram_size  in  2  log2 bytes, forwarded to arsize
inst_sram_addr  in  32  physical byte address
inst_sram_wstrb  in  4  unused
inst_sram_wdata  in  32  unused
inst_sram_addrok  out  1  bridge can accept a request this cycle
inst_sram_dataok  out  1  rdata valid this cycle
inst_sram_rdata  out  32  returned instruction word
ws_cancel  in  1  pipeline flush from WB
arid  out  4  = ARID_VAL
araddr  out  32  latched request address
arlen  out  8  = 0
arsize  out  3  = {1'b0, latched size}
arburst  out  2  = 2'b01
arlock  out  2  = 0
arcache  out  4  = 0
arprot  out  3  = 0
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  4  read id
rdata  in  32  read data
rresp  in  2  ignored
rlast  in  1  ignored (single beat)
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- FSM states: IDLE, AR, R. Reset puts the FSM in IDLE.
- Reset values: arvalid=0, rready=0, dataok=0, discard=0, araddr=0, size_r=0.
- Outputs during reset: addrok=0; rdata is passthrough.
- addrok = (state==IDLE) && !reset.
  - It must not depend combinationally on inst_sram_req, because IF derives req from addrok.
- Accept: req && addrok in cycle T.
  - Latch addr into araddr and size into size_r.
  - Go to AR; arvalid=1 from T+1.
  - If ws_cancel is also high at T, set discard=1.
- AR state: arvalid=1.
  - araddr and arsize stay stable until the handshake (arvalid && arready).
  - On handshake go to R.
- R state: rready=1.
  - On rvalid && rid==ARID_VAL, return to IDLE.
  - dataok = rvalid && rready && !discard, combinational in that cycle.
  - inst_sram_rdata = rdata, passthrough.
  - When rvalid && rready && rid==ARID_VAL, clear discard at the same edge.
- Minimum latency with zero-wait AXI:
  - accept T, AR handshake T+1, R beat and dataok T+2, addrok again T+3.
- ws_cancel in AR or R (or at accept): set discard=1.
  - The transaction still completes on AXI; arvalid is never withdrawn.
  - The response is consumed with dataok held 0.
  - addrok returns only after the FSM reaches IDLE.
- ws_cancel in IDLE with no accept: no effect.
- Cancel coinciding with the R beat: the beat is suppressed (dataok=0).
  - discard is left clear after that edge.
- rresp errors are not reported; the data is passed as-is.
- rvalid with a wrong rid in state R: hold rready=1, ignore the beat and stay in R.
- Reset mid-transaction: immediate return to IDLE with all flags cleared. The AXI slave is reset by the same reset.

Test Plan:
- Single fetch: req=1, addr=0x1fc00000, size=2 at T; arready=1, rvalid=1, rdata=0x3c1d0001 at T+2.
  - Expect addrok=1 at T, arvalid at T+1 with araddr=0x1fc00000, arsize=2, arlen=0.
  - Expect dataok=1 and rdata=0x3c1d0001 at T+2, addrok=1 at T+3.
- AR backpressure: arready=0 for 3 cycles.
  - Expect arvalid and araddr stable throughout, addrok=0 throughout, handshake on the 4th cycle, then normal R.
- R wait states: rvalid delayed 5 cycles.
  - Expect rready=1 throughout, dataok only on the rvalid cycle, exactly one dataok pulse.
- Cancel in flight: ws_cancel pulse in the R state before rvalid.
  - Expect the beat consumed with dataok=0.
  - A next request to 0x1fc00380 then returns its own data with dataok=1.
- Cancel at accept: ws_cancel=1 in the same cycle as req&&addrok.
  - Expect the AXI read still issued and its response suppressed.
- Back-to-back: req held high for 4 fetches, zero-wait AXI.
  - Expect an accept every 3 cycles and in-order dataok with the matching rdata.
- Reset during AR: expect arvalid=0 and addrok=1 the cycle after reset deasserts, with no spurious dataok.
